// File: rtl/divider_unit.sv
// Sequential restoring divider: one quotient bit per cycle, unsigned or two's-complement.
// Operands come from the switch bank; quotient/remainder and status flags are held for display.
module divider_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Load_Dvd,
    input  logic             Load_Dvs,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Dvd_val,
    output logic [WIDTH-1:0] Dvs_val,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero,
    output logic             Ovf
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StSetup, StIter, StFix, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
    logic             done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
    logic [WIDTH:0]   rw_q, rw_d;
    logic [WIDTH-1:0] qw_q, qw_d, dvs_mag_q, dvs_mag_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    // Special cases are detected at setup and only reported when the result lands.
    logic             dbz_pend_q, dbz_pend_d, ovf_pend_q, ovf_pend_d;

    logic [WIDTH-1:0] dvd_mag, dvs_mag, r_low;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Operand magnitudes and the trial subtraction for the current iteration.
    always_comb begin
        dvd_mag = (Signed_Mode && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
        dvs_mag = (Signed_Mode && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        shifted = {rw_q[WIDTH-1:0], qw_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_mag_q};
        r_low   = rw_q[WIDTH-1:0];
    end

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        q_out_d    = q_out_q;
        r_out_d    = r_out_q;
        done_d     = done_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        rw_d       = rw_q;
        qw_d       = qw_q;
        dvs_mag_d  = dvs_mag_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dbz_pend_d = dbz_pend_q;
        ovf_pend_d = ovf_pend_q;

        // Operand loads are only honoured while the datapath is not using them.
        if (state_q == StIdle || state_q == StHold) begin
            if (Load_Dvd) dvd_d = SW;
            if (Load_Dvs) dvs_d = SW;
        end

        unique case (state_q)
            StIdle: begin
                if (Run) state_d = StSetup;
            end
            StSetup: begin
                done_d     = 1'b0;
                dbz_d      = 1'b0;
                ovf_d      = 1'b0;
                q_neg_d    = Signed_Mode & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                r_neg_d    = Signed_Mode & dvd_q[WIDTH-1];
                dvs_mag_d  = dvs_mag;
                rw_d       = '0;
                qw_d       = dvd_mag;
                cnt_d      = '0;
                dbz_pend_d = (dvs_q == '0);
                ovf_pend_d = Signed_Mode && (dvd_q == MinVal) && (dvs_q == '1);
                state_d    = StIter;
            end
            StIter: begin
                // diff's MSB set means the trial subtraction went negative: restore.
                rw_d  = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
                qw_d  = {qw_q[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (dbz_pend_q) begin
                    q_out_d = '1;
                    r_out_d = dvd_q;
                    dbz_d   = 1'b1;
                end else if (ovf_pend_q) begin
                    q_out_d = MinVal;
                    r_out_d = '0;
                    ovf_d   = 1'b1;
                end else begin
                    q_out_d = q_neg_q ? -qw_q : qw_q;
                    r_out_d = r_neg_q ? -r_low : r_low;
                end
                done_d  = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (!Run) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            dvd_q      <= '0;
            dvs_q      <= '0;
            q_out_q    <= '0;
            r_out_q    <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rw_q       <= '0;
            qw_q       <= '0;
            dvs_mag_q  <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            q_out_q    <= q_out_d;
            r_out_q    <= r_out_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            rw_q       <= rw_d;
            qw_q       <= qw_d;
            dvs_mag_q  <= dvs_mag_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dbz_pend_q <= dbz_pend_d;
            ovf_pend_q <= ovf_pend_d;
        end
    end

    // Output drive.
    always_comb begin
        Dvd_val     = dvd_q;
        Dvs_val     = dvs_q;
        Qval        = q_out_q;
        Rval        = r_out_q;
        Done        = done_q;
        Div_By_Zero = dbz_q;
        Ovf         = ovf_q;
        Busy        = (state_q == StSetup) || (state_q == StIter) || (state_q == StFix);
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: stimulus pushes model results, a monitor pops on Done.
module tb_divider_unit;

    localparam int W = 8;
    localparam int LAT = W + 2;  // edges from the Run sample to Done

    logic         Clk, Reset, Run, Load_Dvd, Load_Dvs, Signed_Mode;
    logic [W-1:0] SW, Dvd_val, Dvs_val, Qval, Rval;
    logic         Busy, Done, Div_By_Zero, Ovf;

    divider_unit #(.WIDTH(W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Load_Dvd   (Load_Dvd),
        .Load_Dvs   (Load_Dvs),
        .Signed_Mode(Signed_Mode),
        .SW         (SW),
        .Dvd_val    (Dvd_val),
        .Dvs_val    (Dvs_val),
        .Qval       (Qval),
        .Rval       (Rval),
        .Busy       (Busy),
        .Done       (Done),
        .Div_By_Zero(Div_By_Zero),
        .Ovf        (Ovf)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           e0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    int           pushed = 0;
    int           popped = 0;
    int           cyc = 0;
    logic [W-1:0] cur_dvd, cur_dvs;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                   input int e0);
        exp_t e;
        int   sa, sd, qi, ri;
        e.a = a; e.b = b; e.m = m; e.e0 = e0; e.dbz = 1'b0; e.ovf = 1'b0;
        if (b == 0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
        end else if (m && a == 8'h80 && b == 8'hFF) begin
            e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1;
        end else begin
            if (m) begin
                sa = $signed(a);
                sd = $signed(b);
            end else begin
                sa = int'(a);
                sd = int'(b);
            end
            qi = sa / sd;
            ri = sa % sd;
            e.q = 8'(qi);
            e.r = 8'(ri);
        end
        return e;
    endfunction

    // Monitor: every rising Done must match the oldest outstanding expectation.
    logic prev_done = 1'b0;
    int   busy_run = 0;
    always @(negedge Clk) begin
        exp_t e;
        if (Done && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected no operation pending");
            end else begin
                e = sb.pop_front();
                popped++;
                chk($sformatf("qval a=%0h b=%0h m=%0d", e.a, e.b, e.m), Qval, e.q);
                chk($sformatf("rval a=%0h b=%0h m=%0d", e.a, e.b, e.m), Rval, e.r);
                chk("div_by_zero", Div_By_Zero, e.dbz);
                chk("ovf", Ovf, e.ovf);
                chk("latency", cyc - e.e0, LAT);
                chk("busy_cycles", busy_run, LAT);
            end
            busy_run = 0;
        end else if (Busy) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
        prev_done = Done;
    end

    task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        SW = a; Load_Dvd = 1'b1;
        @(negedge Clk);
        Load_Dvd = 1'b0; SW = b; Load_Dvs = 1'b1;
        @(negedge Clk);
        Load_Dvs = 1'b0;
        cur_dvd = a;
        cur_dvs = b;
        chk("dvd_load", Dvd_val, a);
        chk("dvs_load", Dvs_val, b);
    endtask

    // Raise Run; the next rising edge is e0. Run stays high until released.
    task automatic press(input logic m, input bit push);
        Signed_Mode = m;
        Run = 1'b1;
        if (push) begin
            sb.push_back(model(cur_dvd, cur_dvs, m, cyc + 1));
            pushed++;
        end
        @(negedge Clk);
    endtask

    task automatic wait_done();
        bit fell = 1'b0;
        for (int i = 0; i < 20 && !fell; i++) begin
            @(negedge Clk);
            if (!Busy) fell = 1'b1;
        end
        chk("busy_timeout", fell, 1);
        @(negedge Clk);
        chk("idle_keeps_done", Done, 1);
        chk("idle_not_busy", Busy, 0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        load_ops(a, b);
        press(m, 1'b1);
        Run = 1'b0;
        wait_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dvd"}, Dvd_val, 0);
        chk({tag, "_dvs"}, Dvs_val, 0);
        chk({tag, "_q"}, Qval, 0);
        chk({tag, "_r"}, Rval, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
        chk({tag, "_dbz"}, Div_By_Zero, 0);
        chk({tag, "_ovf"}, Ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [W-1:0] a, b;
        int sel;
        Reset = 1'b1; Run = 1'b0; Load_Dvd = 1'b0; Load_Dvs = 1'b0;
        Signed_Mode = 1'b0; SW = '0;
        repeat (3) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);

        // Directed vectors.
        run_op(8'hC8, 8'h07, 1'b0);
        run_op(8'h9C, 8'h07, 1'b1);
        run_op(8'h64, 8'hF9, 1'b1);
        run_op(8'h80, 8'hFF, 1'b1);
        run_op(8'h80, 8'hFF, 1'b0);
        run_op(8'h2A, 8'h00, 1'b0);
        run_op(8'h2A, 8'h00, 1'b1);
        run_op(8'h05, 8'h09, 1'b0);
        run_op(8'h80, 8'h01, 1'b1);
        run_op(8'hFF, 8'h80, 1'b1);

        // Run held for 50 cycles yields one operation; Done holds through HOLD.
        load_ops(8'h63, 8'h0A);
        press(1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 49; i++) begin
            @(negedge Clk);
            if (seen) begin
                chk("hold_done", Done, 1);
                chk("hold_busy", Busy, 0);
            end
            if (Done && !Busy) seen = 1'b1;
        end
        chk("hold_reached", seen, 1);
        Run = 1'b0;
        @(negedge Clk);

        // Second press clears Done at SETUP; a load during ITER is ignored.
        load_ops(8'hF0, 8'h0D);
        press(1'b0, 1'b1);
        Run = 1'b0;
        @(negedge Clk);
        chk("setup_clears_done", Done, 0);
        chk("setup_busy", Busy, 1);
        @(negedge Clk);
        SW = 8'h11; Load_Dvd = 1'b1;
        @(negedge Clk);
        Load_Dvd = 1'b0;
        chk("dvd_locked_in_iter", Dvd_val, cur_dvd);
        wait_done();

        // Reset during the 4th ITER cycle discards the operation.
        load_ops(8'hC8, 8'h07);
        press(1'b0, 1'b0);
        Run = 1'b0;
        repeat (4) @(negedge Clk);
        chk("pre_reset_busy", Busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        chk_all_zero("mid_reset");
        Reset = 1'b0;
        @(negedge Clk);
        run_op(8'hC8, 8'h07, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 8'h00;
            else if (sel == 1) begin
                a = 8'h80;
                b = 8'hFF;
            end
            run_op(a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("ops_completed", popped, pushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
